// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// instr_loader: packs UART bytes into 32-bit words and writes them into
// instruction memory until a HALT word is seen or memory is full.
// Revision: 1.0
// ============================================================================
module instr_loader #(
  parameter int                NBITS     = 32,
  parameter int                TAM_I     = 256,
  parameter logic [NBITS-1:0]  HALT_WORD = 32'hFFFFFFFF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  output logic [NBITS-1:0] o_address_memory_ins,
  output logic [NBITS-1:0] o_instruction,
  output logic             o_write_intruc,
  output logic             o_busy,
  output logic             o_load_done,
  output logic             o_full,
  output logic [6:0]       o_word_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(TAM_I - 4);
  localparam logic [NBITS-1:0] WORD_STEP = NBITS'(4);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [NBITS-1:0] addr;
  logic [NBITS-1:0] instruction;
  logic [23:0]      partial;
  logic [1:0]       byte_cnt;
  logic [6:0]       word_count;
  logic             full;
  logic             is_halt;
  logic             last_slot;

  assign is_halt   = (instruction == HALT_WORD);
  assign last_slot = (addr == LAST_ADDR);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_enable) next_state = RECV;
      RECV:    if (i_rx_done && (byte_cnt == 2'd3)) next_state = WRITE;
      WRITE:   next_state = (is_halt || last_slot) ? DONE : RECV;
      DONE:    if (i_enable) next_state = RECV;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_write_intruc = 1'b0;
    o_busy         = 1'b0;
    o_load_done    = 1'b0;
    case (state)
      RECV:    o_busy = 1'b1;
      WRITE: begin
        o_busy         = 1'b1;
        o_write_intruc = 1'b1;
      end
      DONE:    o_load_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      addr        <= '0;
      instruction <= '0;
      partial     <= '0;
      byte_cnt    <= '0;
      word_count  <= '0;
      full        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_enable) begin
            addr       <= '0;
            byte_cnt   <= '0;
            word_count <= '0;
            full       <= 1'b0;
          end
        end
        RECV: begin
          if (i_rx_done) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: partial[7:0]   <= i_rx_data;
              2'd1: partial[15:8]  <= i_rx_data;
              2'd2: partial[23:16] <= i_rx_data;
              2'd3: instruction    <= {i_rx_data, partial};
              default: ;
            endcase
          end
        end
        WRITE: begin
          word_count <= word_count + 7'd1;
          // HALT wins over full, so a HALT in the last slot leaves full low
          if (!is_halt) begin
            if (last_slot) begin
              full <= 1'b1;
            end else begin
              addr     <= addr + WORD_STEP;
              byte_cnt <= i_rx_done ? 2'd1 : 2'd0;
              if (i_rx_done) partial[7:0] <= i_rx_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_address_memory_ins = addr;
  assign o_instruction        = instruction;
  assign o_full               = full;
  assign o_word_count         = word_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// tb_instr_loader: directed self-checking bench for instr_loader.
// Revision: 1.0
// ============================================================================
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [31:0] address_memory_ins;
  logic [31:0] instruction;
  logic        write_intruc;
  logic        busy;
  logic        load_done;
  logic        full;
  logic [6:0]  word_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  instr_loader #(.NBITS(32), .TAM_I(256), .HALT_WORD(32'hFFFFFFFF)) dut (
    .i_clk                (clk),
    .i_reset              (rst_n),
    .i_enable             (enable),
    .i_rx_data            (rx_data),
    .i_rx_done            (rx_done),
    .o_address_memory_ins (address_memory_ins),
    .o_instruction        (instruction),
    .o_write_intruc       (write_intruc),
    .o_busy               (busy),
    .o_load_done          (load_done),
    .o_full               (full),
    .o_word_count         (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_intruc) begin
      wr_addr_q.push_back(address_memory_ins);
      wr_data_q.push_back(instruction);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All drivers are entered at a negedge and leave at a negedge
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
    if (idx < wr_addr_q.size()) begin
      check({tag, "_addr"}, wr_addr_q[idx], exp_addr);
      check({tag, "_data"}, wr_data_q[idx], exp_data);
    end else begin
      check({tag, "_missing"}, 32'(wr_addr_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    idle(3);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(load_done), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // T1: reset in the middle of a word
    pulse_enable();
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("t1_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_busy_rst", 32'(busy), 32'd0);
    check("t1_outs_rst", {full, write_intruc, load_done, word_count}, 32'd0);
    check("t1_addr_rst", address_memory_ins, 32'd0);
    check("t1_inst_rst", instruction, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("t1_no_write", 32'(wr_addr_q.size()), 32'd0);
    send_word(32'h12345678);
    idle(2);
    check("t1_idle_ignores", 32'(wr_addr_q.size()), 32'd0);

    // T2: one instruction then HALT
    clear_log();
    pulse_enable();
    send_word(32'h20210013);
    idle(2);
    send_word(32'hFFFFFFFF);
    idle(3);
    check("t2_nwrites", 32'(wr_addr_q.size()), 32'd2);
    check_write("t2_w0", 0, 32'd0, 32'h20210013);
    check_write("t2_w1", 1, 32'd4, 32'hFFFFFFFF);
    check("t2_done",  32'(load_done), 32'd1);
    check("t2_count", 32'(word_count), 32'd2);
    check("t2_full",  32'(full), 32'd0);
    check("t2_busy",  32'(busy), 32'd0);
    send_word(32'h01020304);
    idle(2);
    check("t2_done_ignores", 32'(wr_addr_q.size()), 32'd2);
    check("t2_hold_addr", address_memory_ins, 32'd4);

    // T5: restart from DONE with a lone HALT
    clear_log();
    pulse_enable();
    check("t5_done_clr",  32'(load_done), 32'd0);
    check("t5_count_clr", 32'(word_count), 32'd0);
    send_word(32'hFFFFFFFF);
    idle(3);
    check("t5_nwrites", 32'(wr_addr_q.size()), 32'd1);
    check_write("t5_w0", 0, 32'd0, 32'hFFFFFFFF);
    check("t5_count", 32'(word_count), 32'd1);
    check("t5_full",  32'(full), 32'd0);

    // T6: enable mid-word is ignored
    clear_log();
    pulse_enable();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    pulse_enable();
    send_byte(8'h04);
    idle(2);
    send_word(32'h05060708);
    idle(2);
    send_word(32'hFFFFFFFF);
    idle(3);
    check("t6_nwrites", 32'(wr_addr_q.size()), 32'd3);
    check_write("t6_w0", 0, 32'd0, 32'h04030201);
    check_write("t6_w1", 1, 32'd4, 32'h05060708);
    check("t6_count", 32'(word_count), 32'd3);

    // T4: byte strobe during WRITE starts the next word
    clear_log();
    pulse_enable();
    send_word(32'hDEADBEEF);
    check("t4_latency", 32'(write_intruc), 32'd1);
    send_word(32'hCAFEF00D);
    idle(2);
    send_word(32'hFFFFFFFF);
    idle(3);
    check("t4_nwrites", 32'(wr_addr_q.size()), 32'd3);
    check_write("t4_w0", 0, 32'd0, 32'hDEADBEEF);
    check_write("t4_w1", 1, 32'd4, 32'hCAFEF00D);

    // T3: fill the whole memory with non-HALT words
    clear_log();
    pulse_enable();
    for (int i = 0; i < 64; i++) begin
      send_word({8'(i), 8'h3C, 8'h5A, 8'(i)});
      idle(1);
    end
    idle(2);
    check("t3_nwrites", 32'(wr_addr_q.size()), 32'd64);
    for (int i = 0; i < 64; i += 9) check_write("t3_w", i, 32'(4 * i), {8'(i), 8'h3C, 8'h5A, 8'(i)});
    check_write("t3_last", 63, 32'd252, 32'h3F3C5A3F);
    check("t3_full",  32'(full), 32'd1);
    check("t3_done",  32'(load_done), 32'd1);
    check("t3_count", 32'(word_count), 32'd64);
    send_word(32'h11111111);
    idle(2);
    check("t3_no_more", 32'(wr_addr_q.size()), 32'd64);
    check("t3_addr_hold", address_memory_ins, 32'd252);

    // HALT in the final slot: full must stay low
    clear_log();
    pulse_enable();
    for (int i = 0; i < 63; i++) begin
      send_word(32'h00000013 + 32'(i));
      idle(1);
    end
    send_word(32'hFFFFFFFF);
    idle(3);
    check("hl_nwrites", 32'(wr_addr_q.size()), 32'd64);
    check_write("hl_last", 63, 32'd252, 32'hFFFFFFFF);
    check("hl_full",  32'(full), 32'd0);
    check("hl_count", 32'(word_count), 32'd64);
    check("hl_done",  32'(load_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
